ifm_buf_writer: RTL and testbench
=================================

Name: ifm_buf_writer

Overview:
- Write-side controller for the SIZE-lane IFM buffer bank: the img2col-side producer that drives the buffer's write interface.
- Accepts a stream of SIZE*128-bit pixel words from the img2col datapath and frames it into tiles of ksize*ksize words.
- Generates the buffer's i2c_ready/i2c_done framing, per-lane write enables and addresses, and valid_num.
- Throttles on the buffer's buf_empty so a tile is never written over one the cube has not yet drained.

Parameters:
- SIZE, 8, number of buffer lanes.
- ADDR_W, 5, per-lane write address width.
- LANE_W, 128, per-lane pixel word width.

Ports:
- clock  in  1  single clock, rising edge.
- rst_n  in  1  synchronous reset, active-high: asserted = 1, sampled on the clock edge.
- start  in  1  single-cycle job start; accepted only in IDLE.
- cfg_ksize  in  3  kernel size; legal values 1..5.
- cfg_tiles  in  8  number of tiles in the job; legal values 1..255.
- cfg_lane_mask  in  SIZE  lanes that are written.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  upstream word accept.
- in_data  in  SIZE*LANE_W  pixel word, lane i at bits [i*LANE_W +: LANE_W].
- in_vld_num  in  4  valid 16-bit pixels per lane word, range 0..8.
- buf_empty  in  1  buffer bank drained, driven by the buffer bank.
- ksize  out  3  latched cfg_ksize, to the buffer.
- ifm_wr_en  out  SIZE  per-lane write strobe.
- ifm_wr_addr  out  SIZE*ADDR_W  per-lane address, lane i at bits [i*ADDR_W +: ADDR_W].
- pixels_in  out  SIZE*LANE_W  registered write data.
- valid_num  out  4  registered in_vld_num.
- i2c_ready  out  1  one-cycle pulse: tile write beginning.
- i2c_done  out  1  one-cycle pulse: tile write complete.
- busy  out  1  job in progress.
- cfg_err  out  1  sticky: start was rejected for an illegal config.

Behaviour:

Reset:
- While rst_n = 1, all outputs are 0 and the FSM is in IDLE.
- This applies mid-job as well: the tile is abandoned with no i2c_done pulse.

Start and configuration:
- start in IDLE with cfg_ksize in 1..5, cfg_tiles != 0 and cfg_lane_mask != 0:
  - latch ksize, lane mask and tiles;
  - set tile_len = ksize*ksize (max 25, fits ADDR_W);
  - set busy = 1;
  - go to WAIT_EMPTY.
- start with an illegal config: no job starts, cfg_err = 1.
- cfg_err clears only on reset or on a subsequent legal start.
- start outside IDLE is ignored.

FSM:
- IDLE -> WAIT_EMPTY on a legal start.
- WAIT_EMPTY: in_ready = 0. When buf_empty = 1, go to READY.
- READY: i2c_ready = 1 for exactly this one cycle; clear addr_cnt to 0; go to WRITE.
- WRITE: in_ready = 1. On each cycle with in_valid & in_ready (a beat):
  - next cycle, ifm_wr_en = lane mask;
  - every lane's ifm_wr_addr = addr_cnt;
  - pixels_in = in_data and valid_num = in_vld_num;
  - addr_cnt increments.
  - When the beat has addr_cnt = tile_len-1, in_ready drops in the following cycle and the FSM goes to DONE.
- DONE: i2c_done = 1 for one cycle, which is the cycle after the last ifm_wr_en.
  - Decrement the tile counter.
  - If tiles remain, go to WAIT_EMPTY; otherwise go to IDLE with busy = 0 in that same next cycle.

Timing and hold rules:
- Write latency is 1 cycle from accepted beat to ifm_wr_en.
- ifm_wr_en is 0 on every cycle without a beat; pixels_in and valid_num hold their last value.
- Masked-off lanes keep ifm_wr_en = 0, but their address and data fields still carry the common values.
- A gap in in_valid during WRITE stalls the tile; the address does not advance.
- buf_empty is sampled only in WAIT_EMPTY. A drop of buf_empty during WRITE is ignored, because the buffer is owned by the writer until i2c_done.
- i2c_ready and i2c_done are never asserted in the same cycle.
- There are at least 2 cycles between i2c_done and the next i2c_ready (DONE -> WAIT_EMPTY -> READY).

Test Plan:
- Reset, start ksize=3, tiles=1, mask=8'hFF, buf_empty=1, in_valid held 1 -> i2c_ready pulses once; 9 beats with addr 0..8 on all lanes, ifm_wr_en=8'hFF each cycle; i2c_done one cycle after the addr-8 write; busy falls the same cycle i2c_done rises.
- ksize=5, tiles=2, buf_empty=0 for 20 cycles after the first i2c_done -> the second i2c_ready is delayed until buf_empty=1; each tile writes addresses 0..24; 50 writes in total.
- ksize=2, in_valid toggling 1,0,1,0 -> ifm_wr_en pattern 1,0,1,0; addr sequence 0,1,2,3 with no skips; valid_num tracks in_vld_num with 1-cycle lag.
- start with cfg_ksize=6 (and separately with cfg_tiles=0 and mask=0) -> cfg_err=1, busy=0, no i2c_ready; a following legal start clears cfg_err.
- mask=8'h05, ksize=1 -> only lanes 0 and 2 strobe, once each at addr 0.
- rst_n=1 asserted at addr 4 of a ksize=3 tile -> next cycle all outputs are 0, no i2c_done; a new start runs cleanly from addr 0.

Source files
------------

// File: rtl/ifm_buf_writer_if.sv
// Write-side bus between the img2col producer, the IFM buffer writer and the buffer bank.
interface ifm_buf_writer_if #(
  parameter int unsigned SIZE   = 8,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned LANE_W = 128
);
  // Upstream pixel stream
  logic                     in_valid;
  logic                     in_ready;
  logic [SIZE*LANE_W-1:0]   in_data;
  logic [3:0]               in_vld_num;

  // Buffer bank write side
  logic                     buf_empty;
  logic [2:0]               ksize;
  logic [SIZE-1:0]          ifm_wr_en;
  logic [SIZE*ADDR_W-1:0]   ifm_wr_addr;
  logic [SIZE*LANE_W-1:0]   pixels_in;
  logic [3:0]               valid_num;
  logic                     i2c_ready;
  logic                     i2c_done;

  // The writer: consumes the stream, drives the buffer
  modport master (
    input  in_valid, in_data, in_vld_num, buf_empty,
    output in_ready, ksize, ifm_wr_en, ifm_wr_addr, pixels_in, valid_num,
           i2c_ready, i2c_done
  );

  // The environment: producer plus buffer bank
  modport slave (
    output in_valid, in_data, in_vld_num, buf_empty,
    input  in_ready, ksize, ifm_wr_en, ifm_wr_addr, pixels_in, valid_num,
           i2c_ready, i2c_done
  );
endinterface

// File: rtl/ifm_buf_writer.sv
// IFM buffer write controller: frames the img2col word stream into ksize*ksize
// tiles, generates i2c_ready/i2c_done framing and per-lane write strobes.
module ifm_buf_writer #(
  parameter int unsigned SIZE   = 8,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned LANE_W = 128
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        cfg_ksize,
  input  logic [7:0]        cfg_tiles,
  input  logic [SIZE-1:0]   cfg_lane_mask,
  ifm_buf_writer_if.master  bus,
  output logic              busy,
  output logic              cfg_err
);

  localparam int unsigned SQ_W = 6;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WAIT_EMPTY = 3'd1;
  localparam logic [2:0] S_READY      = 3'd2;
  localparam logic [2:0] S_WRITE      = 3'd3;
  localparam logic [2:0] S_DONE       = 3'd4;

  logic [2:0]        state;
  logic [2:0]        state_nx;
  logic [SIZE-1:0]   lane_mask;
  logic [7:0]        tiles_left;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] addr_cnt;

  logic              cfg_legal;
  logic              beat;
  logic              last_beat;
  logic [SQ_W-1:0]   ksq;

  // Next-state logic and beat qualification
  always_comb begin
    state_nx  = state;
    cfg_legal = (cfg_ksize != 3'd0) && (cfg_ksize <= 3'd5) &&
                (cfg_tiles != 8'd0) && (|cfg_lane_mask);
    ksq       = SQ_W'(cfg_ksize) * SQ_W'(cfg_ksize);
    beat      = (state == S_WRITE) && bus.in_valid && bus.in_ready;
    last_beat = beat && (addr_cnt == last_addr);

    case (state)
      S_IDLE: begin
        if (start && cfg_legal) state_nx = S_WAIT_EMPTY;
      end
      // buf_empty is stale while the buffer is still seeing our i2c_done pulse
      S_WAIT_EMPTY: begin
        if (bus.buf_empty && !bus.i2c_done) state_nx = S_READY;
      end
      S_READY: begin
        state_nx = S_WRITE;
      end
      S_WRITE: begin
        if (last_beat) state_nx = S_DONE;
      end
      S_DONE: begin
        state_nx = (tiles_left == 8'd1) ? S_IDLE : S_WAIT_EMPTY;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Job configuration, tile counting and status flags
  always_ff @(posedge clock) begin
    if (rst_n) begin
      bus.ksize  <= '0;
      lane_mask  <= '0;
      tiles_left <= '0;
      last_addr  <= '0;
      busy       <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        if (cfg_legal) begin
          bus.ksize  <= cfg_ksize;
          lane_mask  <= cfg_lane_mask;
          tiles_left <= cfg_tiles;
          last_addr  <= ADDR_W'(ksq - SQ_W'(1));
          busy       <= 1'b1;
          cfg_err    <= 1'b0;
        end else begin
          cfg_err    <= 1'b1;
        end
      end
      if (state == S_DONE) begin
        tiles_left <= tiles_left - 8'd1;
        if (tiles_left == 8'd1) busy <= 1'b0;
      end
    end
  end

  // Handshake and framing pulses, all registered from the FSM
  always_ff @(posedge clock) begin
    if (rst_n) begin
      bus.in_ready  <= 1'b0;
      bus.i2c_ready <= 1'b0;
      bus.i2c_done  <= 1'b0;
    end else begin
      bus.in_ready  <= (state_nx == S_WRITE);
      bus.i2c_ready <= (state_nx == S_READY);
      bus.i2c_done  <= (state == S_DONE);
    end
  end

  // Write datapath: one-cycle latency from accepted beat to lane strobe
  always_ff @(posedge clock) begin
    if (rst_n) begin
      addr_cnt        <= '0;
      bus.ifm_wr_en   <= '0;
      bus.ifm_wr_addr <= '0;
      bus.pixels_in   <= '0;
      bus.valid_num   <= '0;
    end else begin
      if (state == S_READY) begin
        addr_cnt <= '0;
      end else if (beat) begin
        addr_cnt <= addr_cnt + ADDR_W'(1);
      end
      bus.ifm_wr_en <= beat ? lane_mask : '0;
      if (beat) begin
        bus.ifm_wr_addr <= {SIZE{addr_cnt}};
        bus.pixels_in   <= bus.in_data;
        bus.valid_num   <= bus.in_vld_num;
      end
    end
  end

endmodule

// File: tb/tb_ifm_buf_writer.sv
// Scoreboard bench for ifm_buf_writer: the driver queues expected writes,
// a negedge monitor pops and compares every strobed write.
module tb_ifm_buf_writer;

  localparam int unsigned SIZE   = 8;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned LANE_W = 128;
  localparam int unsigned DW     = SIZE * LANE_W;

  typedef struct {
    logic [SIZE-1:0]   mask;
    logic [ADDR_W-1:0] addr;
    logic [DW-1:0]     data;
    logic [3:0]        vld;
  } wr_t;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  logic            clock;
  logic            rst_n;
  logic            start;
  logic [2:0]      cfg_ksize;
  logic [7:0]      cfg_tiles;
  logic [SIZE-1:0] cfg_lane_mask;
  logic            busy;
  logic            cfg_err;

  ifm_buf_writer_if #(.SIZE(SIZE), .ADDR_W(ADDR_W), .LANE_W(LANE_W)) bus ();

  ifm_buf_writer #(.SIZE(SIZE), .ADDR_W(ADDR_W), .LANE_W(LANE_W)) dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .start        (start),
    .cfg_ksize    (cfg_ksize),
    .cfg_tiles    (cfg_tiles),
    .cfg_lane_mask(cfg_lane_mask),
    .bus          (bus),
    .busy         (busy),
    .cfg_err      (cfg_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  wr_t  exp_q[$];
  chk_t chk_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ready_cnt = 0;
  int done_cnt = 0;
  int wr_cnt = 0;
  int last_done = -100;

  chk_t mon_c;
  wr_t  mon_e;
  logic mon_bad;

  // Monitor: sole owner of the comparison counters
  always @(negedge clock) begin
    cyc = cyc + 1;
    while (chk_q.size() > 0) begin
      mon_c = chk_q.pop_front();
      n_cmp = n_cmp + 1;
      if (mon_c.act !== mon_c.exp) begin
        n_bad = n_bad + 1;
        $display("FAIL %s: got %0d want %0d", mon_c.name, mon_c.act, mon_c.exp);
      end
    end
    if (|bus.ifm_wr_en) begin
      wr_cnt = wr_cnt + 1;
      n_cmp  = n_cmp + 1;
      if (exp_q.size() == 0) begin
        n_bad = n_bad + 1;
        $display("FAIL unexpected_write: wr_en=%h addr0=%0d, nothing expected",
                 bus.ifm_wr_en, bus.ifm_wr_addr[ADDR_W-1:0]);
      end else begin
        mon_e   = exp_q.pop_front();
        mon_bad = 1'b0;
        if (bus.ifm_wr_en !== mon_e.mask) mon_bad = 1'b1;
        for (int l = 0; l < SIZE; l++)
          if (bus.ifm_wr_addr[l*ADDR_W +: ADDR_W] !== mon_e.addr) mon_bad = 1'b1;
        if (bus.pixels_in !== mon_e.data) mon_bad = 1'b1;
        if (bus.valid_num !== mon_e.vld) mon_bad = 1'b1;
        if (mon_bad) begin
          n_bad = n_bad + 1;
          $display("FAIL write: got en=%h addr=%h vld=%0d data_ok=%0d want en=%h addr=%0d vld=%0d",
                   bus.ifm_wr_en, bus.ifm_wr_addr, bus.valid_num,
                   bus.pixels_in === mon_e.data, mon_e.mask, mon_e.addr, mon_e.vld);
        end
      end
    end
    if (bus.i2c_ready || bus.i2c_done) begin
      n_cmp = n_cmp + 1;
      if (bus.i2c_ready && bus.i2c_done) begin
        n_bad = n_bad + 1;
        $display("FAIL ready_done_overlap: got both 1 want exclusive");
      end
    end
    if (bus.i2c_ready) begin
      ready_cnt = ready_cnt + 1;
      n_cmp = n_cmp + 1;
      if (cyc - last_done < 2) begin
        n_bad = n_bad + 1;
        $display("FAIL done_to_ready_gap: got %0d want >=2", cyc - last_done);
      end
    end
    if (bus.i2c_done) begin
      done_cnt  = done_cnt + 1;
      last_done = cyc;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.act  = act;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  function automatic logic [DW-1:0] mk_data(input int tag, input int idx);
    logic [DW-1:0] d;
    for (int l = 0; l < SIZE; l++)
      d[l*LANE_W +: LANE_W] = {32'(tag), 32'(l), 32'(idx), 32'hC0DE_0000 ^ 32'(idx * 7 + l)};
    return d;
  endfunction

  task automatic start_job(input int k, input int t, input logic [SIZE-1:0] m);
    cfg_ksize     = 3'(k);
    cfg_tiles     = 8'(t);
    cfg_lane_mask = m;
    start         = 1'b1;
    tick();
    start         = 1'b0;
  endtask

  // Offer one word, wait for acceptance, queue the expected write
  task automatic send_word(input int tag, input int idx, input logic [SIZE-1:0] m);
    int  n;
    wr_t e;
    n = 0;
    bus.in_valid   = 1'b1;
    bus.in_data    = mk_data(tag, idx);
    bus.in_vld_num = 4'((idx * 3 + tag) % 9);
    @(negedge clock);
    while (!bus.in_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!bus.in_ready) begin
      chk("in_ready_timeout", 32'd0, 32'd1);
    end else begin
      e.mask = m;
      e.addr = ADDR_W'(idx);
      e.data = bus.in_data;
      e.vld  = bus.in_vld_num;
      exp_q.push_back(e);
    end
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_tile(input int tag, input int len, input logic [SIZE-1:0] m, input bit gap);
    for (int i = 0; i < len; i++) begin
      send_word(tag, i, m);
      if (gap) tick();
    end
  endtask

  task automatic wait_done(input string name, input logic exp_busy);
    int n;
    n = 0;
    @(negedge clock);
    while (!bus.i2c_done && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (!bus.i2c_done) chk({name, "_done_timeout"}, 32'd0, 32'd1);
    else chk({name, "_busy_at_done"}, 32'(busy), 32'(exp_busy));
  endtask

  int r0, d0, w0, seen;

  initial begin
    rst_n          = 1'b1;
    start          = 1'b0;
    cfg_ksize      = 3'd0;
    cfg_tiles      = 8'd0;
    cfg_lane_mask  = '0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_vld_num = 4'd0;
    bus.buf_empty  = 1'b1;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_wr_en", 32'(bus.ifm_wr_en), 32'd0);
    chk("rst_i2c_ready", 32'(bus.i2c_ready), 32'd0);
    rst_n = 1'b0;
    tick();

    // ksize=3, single tile, all lanes, continuous stream
    r0 = ready_cnt; d0 = done_cnt; w0 = wr_cnt;
    start_job(3, 1, 8'hFF);
    chk("t1_busy_after_start", 32'(busy), 32'd1);
    chk("t1_ksize", 32'(bus.ksize), 32'd3);
    send_tile(1, 9, 8'hFF, 1'b0);
    wait_done("t1", 1'b0);
    tick(); tick();
    chk("t1_ready_cnt", 32'(ready_cnt - r0), 32'd1);
    chk("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("t1_writes", 32'(wr_cnt - w0), 32'd9);

    // ksize=5, two tiles, buffer not drained for 20 cycles in between
    r0 = ready_cnt; w0 = wr_cnt;
    start_job(5, 2, 8'hFF);
    send_tile(2, 25, 8'hFF, 1'b0);
    wait_done("t2a", 1'b1);
    bus.buf_empty = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clock);
      if (bus.i2c_ready || bus.in_ready) seen++;
    end
    chk("t2_held_while_full", 32'(seen), 32'd0);
    chk("t2_busy_while_full", 32'(busy), 32'd1);
    bus.buf_empty = 1'b1;
    send_tile(3, 25, 8'hFF, 1'b0);
    wait_done("t2b", 1'b0);
    tick(); tick();
    chk("t2_ready_cnt", 32'(ready_cnt - r0), 32'd2);
    chk("t2_writes", 32'(wr_cnt - w0), 32'd50);

    // ksize=2 with in_valid toggling every cycle
    w0 = wr_cnt;
    start_job(2, 1, 8'hFF);
    send_tile(4, 4, 8'hFF, 1'b1);
    wait_done("t3", 1'b0);
    tick();
    chk("t3_writes", 32'(wr_cnt - w0), 32'd4);

    // Illegal configs set cfg_err; legal start (ksize=1, mask 05) clears it
    r0 = ready_cnt; w0 = wr_cnt;
    start_job(6, 1, 8'hFF);
    tick();
    chk("t4_err_ksize6", 32'(cfg_err), 32'd1);
    chk("t4_busy_ksize6", 32'(busy), 32'd0);
    start_job(1, 1, 8'h05);
    chk("t4_err_cleared1", 32'(cfg_err), 32'd0);
    send_tile(5, 1, 8'h05, 1'b0);
    wait_done("t5a", 1'b0);
    tick();
    start_job(3, 0, 8'hFF);
    tick();
    chk("t4_err_tiles0", 32'(cfg_err), 32'd1);
    chk("t4_busy_tiles0", 32'(busy), 32'd0);
    start_job(1, 1, 8'h05);
    chk("t4_err_cleared2", 32'(cfg_err), 32'd0);
    send_tile(6, 1, 8'h05, 1'b0);
    wait_done("t5b", 1'b0);
    tick();
    start_job(3, 1, 8'h00);
    repeat (4) tick();
    chk("t4_err_mask0", 32'(cfg_err), 32'd1);
    chk("t4_busy_mask0", 32'(busy), 32'd0);
    chk("t4_ready_cnt", 32'(ready_cnt - r0), 32'd2);
    chk("t5_writes", 32'(wr_cnt - w0), 32'd2);

    // Reset in the middle of a ksize=3 tile, then a clean rerun
    d0 = done_cnt;
    start_job(3, 1, 8'hFF);
    for (int i = 0; i < 4; i++) send_word(7, i, 8'hFF);
    bus.in_valid   = 1'b1;
    bus.in_data    = mk_data(7, 4);
    bus.in_vld_num = 4'd4;
    rst_n = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("mr_wr_en", 32'(bus.ifm_wr_en), 32'd0);
    chk("mr_wr_addr", 32'(|bus.ifm_wr_addr), 32'd0);
    chk("mr_pixels", 32'(|bus.pixels_in), 32'd0);
    chk("mr_valid_num", 32'(bus.valid_num), 32'd0);
    chk("mr_in_ready", 32'(bus.in_ready), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_ksize", 32'(bus.ksize), 32'd0);
    chk("mr_i2c_ready", 32'(bus.i2c_ready), 32'd0);
    tick();
    rst_n = 1'b0;
    repeat (3) tick();
    chk("mr_no_done", 32'(done_cnt - d0), 32'd0);
    w0 = wr_cnt;
    start_job(3, 1, 8'hFF);
    send_tile(8, 9, 8'hFF, 1'b0);
    wait_done("mr_rerun", 1'b0);
    tick();
    chk("mr_rerun_writes", 32'(wr_cnt - w0), 32'd9);

    repeat (5) tick();
    chk("exp_q_left", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 20 && chk_q.size() > 0; i++) tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
